// File: rtl/card_hand_buffer.sv
// card_hand_buffer: per-hand card register, newest card in slot 0, with count/full/empty flags.
// Define CARD_HAND_SCORE_EN to build the running blackjack score (soft ace, bust detection).
module card_hand_buffer #(
  parameter int CARD_W  = 8,
  parameter int DEPTH   = 11,
  parameter int SCORE_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [CARD_W-1:0]          card_i,
  output logic [DEPTH*CARD_W-1:0]    hand_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       push_err_o,
  output logic [SCORE_W-1:0]         score_o,
  output logic                       soft_o,
  output logic                       bust_o
);

  localparam int               CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH*CARD_W-1:0] hand_p1;
  logic [CNT_W-1:0]        count_p1;
  logic                    err_p1;

  logic [3:0] rank_p0;
  logic       rank_ok_p0;
  logic       full_p0;
  logic       push_ok_p0;
  logic       push_rej_p0;

  assign rank_p0     = card_i[3:0];
  assign rank_ok_p0  = (rank_p0 != 4'd0) && (rank_p0 <= 4'd13);
  assign full_p0     = (count_p1 == CNT_FULL);
  // A clear on the same edge swallows the push silently, so it never raises an error.
  assign push_ok_p0  = push_i && !clr_i && !full_p0 && rank_ok_p0;
  assign push_rej_p0 = push_i && !clr_i && (full_p0 || !rank_ok_p0);

  // p0 -> p1: register the shifted hand, the card count and the reject flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hand_p1  <= '0;
      count_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (clr_i) begin
      hand_p1  <= '0;
      count_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      err_p1 <= push_rej_p0;
      if (push_ok_p0) begin
        hand_p1  <= {hand_p1[(DEPTH-1)*CARD_W-1:0], card_i};
        count_p1 <= count_p1 + CNT_W'(1);
      end
    end
  end

  assign hand_o     = hand_p1;
  assign count_o    = count_p1;
  assign empty_o    = (count_p1 == '0);
  assign full_o     = full_p0;
  assign push_err_o = err_p1;

`ifdef CARD_HAND_SCORE_EN
  logic [SCORE_W-1:0] hard_p1;
  logic               ace_p1;

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0]         v);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(v);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // p0 -> p1: hard total (aces as 1) and whether any ace has been dealt
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hard_p1 <= '0;
      ace_p1  <= 1'b0;
    end else if (clr_i) begin
      hard_p1 <= '0;
      ace_p1  <= 1'b0;
    end else if (push_ok_p0) begin
      hard_p1 <= sat_add(hard_p1, card_value(rank_p0));
      if (rank_p0 == 4'd1) ace_p1 <= 1'b1;
    end
  end

  // Only one ace can ever be promoted to 11 without busting, hence the single +10.
  assign soft_o  = ace_p1 && (hard_p1 <= SCORE_W'(11));
  assign score_o = soft_o ? hard_p1 + SCORE_W'(10) : hard_p1;
  assign bust_o  = (hard_p1 > SCORE_W'(21));
`else
  assign score_o = '0;
  assign soft_o  = 1'b0;
  assign bust_o  = 1'b0;
`endif

endmodule

// File: tb/tb_card_hand_buffer.sv
// Testbench for card_hand_buffer: queue-based hand model checked every cycle, directed and random stimulus.
module tb_card_hand_buffer;

  localparam int CARD_W  = 8;
  localparam int DEPTH   = 11;
  localparam int SCORE_W = 8;
  localparam int CNT_W   = $clog2(DEPTH+1);
`ifdef CARD_HAND_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic                    clr_i = 1'b0;
  logic                    push_i = 1'b0;
  logic [CARD_W-1:0]       card_i = '0;
  logic [DEPTH*CARD_W-1:0] hand_o;
  logic [CNT_W-1:0]        count_o;
  logic                    empty_o, full_o, push_err_o, soft_o, bust_o;
  logic [SCORE_W-1:0]      score_o;

  card_hand_buffer #(.CARD_W(CARD_W), .DEPTH(DEPTH), .SCORE_W(SCORE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .push_i(push_i), .card_i(card_i),
    .hand_o(hand_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .push_err_o(push_err_o), .score_o(score_o), .soft_o(soft_o), .bust_o(bust_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the hand is a queue of card codes, newest at the front.
  logic [CARD_W-1:0] mq[$];
  int m_hard = 0;
  bit m_ace  = 1'b0;
  bit m_err  = 1'b0;

  always @(posedge clk_i or negedge rst_i) begin
    int r;
    if (!rst_i || clr_i) begin
      mq.delete();
      m_hard = 0;
      m_ace  = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (push_i) begin
        r = int'(card_i[3:0]);
        if (mq.size() == DEPTH || r == 0 || r > 13) m_err = 1'b1;
        else begin
          mq.push_front(card_i);
          m_hard = m_hard + ((r > 10) ? 10 : r);
          if (m_hard > 2**SCORE_W - 1) m_hard = 2**SCORE_W - 1;
          if (r == 1) m_ace = 1'b1;
        end
      end
    end
  end

  function automatic bit m_soft();
    return SCORE_EN && m_ace && m_hard <= 11;
  endfunction

  function automatic int m_score();
    if (!SCORE_EN) return 0;
    return m_soft() ? m_hard + 10 : m_hard;
  endfunction

  always @(negedge clk_i) begin
    logic [DEPTH*CARD_W-1:0] exp_hand;
    if (chk_en) begin
      exp_hand = '0;
      foreach (mq[k]) exp_hand[k*CARD_W +: CARD_W] = mq[k];
      check("hand", 128'(hand_o), 128'(exp_hand));
      check("count", 128'(count_o), 128'(mq.size()));
      check("empty", 128'(empty_o), 128'(mq.size() == 0));
      check("full", 128'(full_o), 128'(mq.size() == DEPTH));
      check("push_err", 128'(push_err_o), 128'(m_err));
      check("score", 128'(score_o), 128'(m_score()));
      check("soft", 128'(soft_o), 128'(m_soft()));
      check("bust", 128'(bust_o), 128'(SCORE_EN && m_hard > 21));
    end
  end

  task automatic push1(input logic [CARD_W-1:0] c);
    push_i = 1'b1;
    card_i = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic stop_push();
    push_i = 1'b0;
    card_i = '0;
  endtask

  task automatic clear_hand();
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    @(negedge clk_i);
    check("rst_count", 128'(count_o), 128'(0));
    check("rst_empty", 128'(empty_o), 128'(1));
    check("rst_full", 128'(full_o), 128'(0));
    check("rst_hand", 128'(hand_o), 128'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Shift order with pass-through upper bits
    push1(8'h15); push1(8'h29); push1(8'h32); stop_push();
    @(negedge clk_i);
    check("slot0", 128'(hand_o[7:0]), 128'(8'h32));
    check("slot1", 128'(hand_o[15:8]), 128'(8'h29));
    check("slot2", 128'(hand_o[23:16]), 128'(8'h15));
    check("shift_count", 128'(count_o), 128'(3));
    check("shift_score", 128'(score_o), 128'(SCORE_EN ? 16 : 0));
    check("shift_soft", 128'(soft_o), 128'(0));

    // Asynchronous reset mid-hand, observed between clock edges
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("async_count", 128'(count_o), 128'(0));
    check("async_hand", 128'(hand_o), 128'(0));
    check("async_empty", 128'(empty_o), 128'(1));
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Soft ace
    push1(8'h01); push1(8'h06); stop_push();
    @(negedge clk_i);
    check("soft_score", 128'(score_o), 128'(SCORE_EN ? 17 : 0));
    check("soft_flag", 128'(soft_o), 128'(SCORE_EN));
    @(posedge clk_i); #1;
    push1(8'h09); stop_push();
    @(negedge clk_i);
    check("hard_score", 128'(score_o), 128'(SCORE_EN ? 16 : 0));
    check("hard_soft", 128'(soft_o), 128'(0));
    check("hard_bust", 128'(bust_o), 128'(0));

    // Faces and bust; bust does not block further pushes
    @(posedge clk_i); #1;
    clear_hand();
    push1(8'h0D); push1(8'h0C); push1(8'h05); stop_push();
    @(negedge clk_i);
    check("bust_score", 128'(score_o), 128'(SCORE_EN ? 25 : 0));
    check("bust_flag", 128'(bust_o), 128'(SCORE_EN));
    @(posedge clk_i); #1;
    push1(8'h03); stop_push();
    check("bust_push_count", 128'(count_o), 128'(4));

    // Fill with aces, then overflow
    clear_hand();
    for (int i = 0; i < DEPTH; i++) push1(8'h01);
    stop_push();
    check("aces_full", 128'(full_o), 128'(1));
    check("aces_score", 128'(score_o), 128'(SCORE_EN ? 21 : 0));
    check("aces_soft", 128'(soft_o), 128'(SCORE_EN));
    push1(8'h01); stop_push();
    check("ovf_err", 128'(push_err_o), 128'(1));
    check("ovf_count", 128'(count_o), 128'(DEPTH));
    @(posedge clk_i); #1;
    check("ovf_err_drop", 128'(push_err_o), 128'(0));

    // Illegal ranks
    clear_hand();
    push1(8'h02); push1(8'h07); stop_push();
    push1(8'h40); stop_push();
    check("rank0_err", 128'(push_err_o), 128'(1));
    check("rank0_count", 128'(count_o), 128'(2));
    push1(8'h0E); stop_push();
    check("rank14_err", 128'(push_err_o), 128'(1));
    check("rank14_count", 128'(count_o), 128'(2));

    // Clear wins over a simultaneous push
    push1(8'h04); push1(8'h08); stop_push();
    clr_i = 1'b1; push_i = 1'b1; card_i = 8'h05;
    @(posedge clk_i); #1;
    clr_i = 1'b0; stop_push();
    check("clr_count", 128'(count_o), 128'(0));
    check("clr_err", 128'(push_err_o), 128'(0));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      clr_i  = ($urandom_range(0, 99) < 2);
      push_i = ($urandom_range(0, 99) < 70);
      card_i = CARD_W'($urandom);
      if ($urandom_range(0, 9) < 8) card_i[3:0] = 4'($urandom_range(1, 13));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_i = 1'b0;
        #1 rst_i = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    clr_i = 1'b0;
    stop_push();
    @(negedge clk_i);
    @(negedge clk_i);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/card_hand_buffer.md
# card_hand_buffer

Parametrised hand register for the blackjack datapath. It stores up to DEPTH dealt cards per hand, newest card in slot 0, and shifts older cards toward higher slots. It also keeps a card count, full/empty flags and an optional running blackjack score with soft-ace and bust detection. It sits between the card dealer and the game controller, one instance per hand (player or dealer). It supersedes the fixed 11-slot, 8-bit card stack.

## Interface
- CARD_W, default 8: width of one card code; bits [3:0] carry rank 1..13 (1=A, 11..13=J/Q/K), upper bits are passed through unchanged.
- DEPTH, default 11: number of card slots, minimum 2.
- SCORE_W, default 8: width of the score accumulator.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous hand clear (new round).
- push_i  in  1  single-cycle strobe: store card_i this cycle.
- card_i  in  CARD_W  card code, sampled when push_i=1.
- hand_o  out  DEPTH*CARD_W  slot k at bits [k*CARD_W +: CARD_W]; slot 0 is the newest card.
- count_o  out  $clog2(DEPTH+1)  number of valid cards.
- empty_o  out  1  count_o==0.
- full_o  out  1  count_o==DEPTH.
- push_err_o  out  1  one-cycle pulse when a push is rejected.
- score_o  out  SCORE_W  best blackjack score of the hand.
- soft_o  out  1  score_o counts one ace as 11.
- bust_o  out  1  score_o>21.

## Operation
- **Reset** (rst_i=0, immediate):
  - all slots 0, count_o 0, hard_sum 0, ace_seen 0, push_err_o 0.
  - Outputs therefore read: hand_o 0, empty_o 1, full_o 0, score_o 0, soft_o 0, bust_o 0.
- **Priority per edge:** clr_i > push_i.
  - clr_i=1: same result as reset, but synchronous. A simultaneous push is dropped without an error pulse.
- **Accepted push:** push_i=1, not full, and rank in 1..13.
  - Slot k takes slot k-1 for k=1..DEPTH-1; slot 0 takes card_i.
  - count_o increments by 1.
- **Rejected push:** full, or rank is 0 or >13.
  - No state change; push_err_o=1 on the next cycle.
- Slots at index >= count_o always read 0.
- **Card value:** rank 11..13 counts as 10; rank 1 counts as 1 and sets ace_seen.
- **Accumulator:** hard_sum += value on each accepted push. It saturates at 2^SCORE_W-1 and never wraps.
- **Score outputs** (combinational from registers):
  - score_o = hard_sum + 10 if ace_seen && hard_sum<=11, else hard_sum.
  - soft_o is 1 exactly when that +10 is applied.
  - bust_o = (hard_sum>21).
- Bust does not block pushes. The controller decides when to stop dealing.
- The block has no FSM. State is count, slots, hard_sum, ace_seen and a registered error flag.

## Timing
- **Latency:** an accepted push at edge N is visible on hand_o, count_o, full_o, empty_o and score_o after edge N. This is one cycle of latency; there is no combinational path from push_i or card_i to any output.
- **Back-to-back pushes:** one per cycle is sustained until full.
- push_err_o is registered, high for exactly the one cycle following the rejected edge.
- Reset asserted mid-operation clears everything asynchronously. The first push is accepted on the first rising edge after rst_i deasserts.
- A push on the cycle count_o reaches DEPTH-1 is accepted and sets full. The next push is rejected.

## Configuration
- **CARD_HAND_SCORE_EN defined:** the value decode, hard_sum, ace_seen and score/soft/bust logic are built as specified above.
- **CARD_HAND_SCORE_EN undefined:** the scoring logic is not synthesised. score_o ties to 0 and soft_o/bust_o tie to 0. Storage, count, flags and push_err_o are unchanged, so the block acts as a generic parametrised card buffer.

## Test plan
- **Reset/empty:** assert rst_i mid-hand with 3 cards stored -> hand_o=0, count_o=0, empty_o=1 immediately, without a clock edge.
- **Shift order:** push ranks 5, 9, 2 on consecutive cycles -> slot0=2, slot1=9, slot2=5, count_o=3, score_o=16, soft_o=0.
- **Soft ace:** push A then 6 -> score_o=17, soft_o=1; then push 9 -> score_o=16, soft_o=0, bust_o=0.
- **Bust and faces:** push K, Q, 5 -> score_o=25, bust_o=1; the next push is still accepted, and count_o=4.
- **Full/reject:** with DEPTH=11, push 11 aces -> full_o=1, score_o=21, soft_o=1; a 12th push -> push_err_o pulses one cycle and state is unchanged. A separate push of rank 0 or 14 -> push_err_o pulses and count_o is unchanged.
- **Clear priority:** clr_i and push_i high on the same edge with 4 cards stored -> count_o=0, push_err_o=0. Rerun with CARD_HAND_SCORE_EN undefined -> score_o=0 throughout.
